deadlock_timeout_ctrl: RTL and testbench

Downstream consumer of the per-module deadlock monitor outputs (`block`, `axis_block_info`) in the C/RTL cosimulation harness. It filters transient AXI-Stream stalls by requiring `block` to stay asserted for `TIMEOUT` consecutive cycles. It then captures and decodes which stream channels were stalled and hands a single deadlock report to the testbench logger over a valid/ready handshake. After the report is accepted, it holds a sticky `deadlock` flag until reset.

---
 rtl/deadlock_timeout_ctrl.sv | 135 +++++++++++++
 tb/tb_deadlock_timeout_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/deadlock_timeout_ctrl.sv
// deadlock_timeout_ctrl
// Filters transient AXI-Stream stalls reported by the deadlock monitor. When
// `block` stays high for TIMEOUT consecutive cycles, it captures and decodes the
// stalled channels. It then offers one report to the logger over valid/ready and
// keeps a sticky `deadlock` flag until reset.
//
// Ports:
//   clock            in   rising-edge clock
//   reset            in   synchronous, active-high reset
//   block            in   monitor block indication
//   axis_block_info  in   per-channel block info (2 bits per channel)
//   done_in          in   design finished; suppresses detection
//   report_valid     out  deadlock report available
//   report_ready     in   logger accepts the report
//   report_info      out  axis_block_info captured at detection
//   report_chan      out  bit i set iff captured field i is nonzero
//   stall_cnt        out  consecutive blocked-cycle count (saturating)
//   deadlock         out  sticky deadlock flag
module deadlock_timeout_ctrl #(
  parameter int unsigned NUM_AXIS = 2,
  parameter int unsigned INFO_W   = 2 * NUM_AXIS,
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                block,
  input  logic [INFO_W-1:0]   axis_block_info,
  input  logic                done_in,
  output logic                report_valid,
  input  logic                report_ready,
  output logic [INFO_W-1:0]   report_info,
  output logic [NUM_AXIS-1:0] report_chan,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic                deadlock
);

  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] THRESH    = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SUSPECT  = 2'd1,
    REPORT   = 2'd2,
    DEADLOCK = 2'd3
  } state_t;

  state_t              state_q;
  logic                report_valid_q;
  logic [INFO_W-1:0]   report_info_q;
  logic [NUM_AXIS-1:0] report_chan_q;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic                deadlock_q;

  logic [CNT_W-1:0]    cnt_sat_d;
  logic [NUM_AXIS-1:0] chan_d;

  // Saturating increment; never wraps past all-ones.
  always_comb begin
    cnt_sat_d = stall_cnt_q;
    if (stall_cnt_q != {CNT_W{1'b1}}) begin
      cnt_sat_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Per-channel decode of the live info, taken only at the capture edge.
  always_comb begin
    chan_d = '0;
    for (int i = 0; i < int'(NUM_AXIS); i++) begin
      chan_d[i] = |axis_block_info[2*i +: 2];
    end
  end

  // Detection FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      report_valid_q <= 1'b0;
      report_info_q  <= '0;
      report_chan_q  <= '0;
      stall_cnt_q    <= '0;
      deadlock_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (block && !done_in) begin
            state_q     <= SUSPECT;
            stall_cnt_q <= CNT_W'(1);
          end
        end
        SUSPECT: begin
          // done_in outranks block so a finished design never reports.
          if (done_in || !block) begin
            state_q     <= IDLE;
            stall_cnt_q <= '0;
          end else if (stall_cnt_q == THRESH_M1) begin
            state_q        <= REPORT;
            stall_cnt_q    <= THRESH;
            report_valid_q <= 1'b1;
            report_info_q  <= axis_block_info;
            report_chan_q  <= chan_d;
          end else begin
            stall_cnt_q <= cnt_sat_d;
          end
        end
        REPORT: begin
          // Report is never withdrawn; only the handshake moves us on.
          if (block) begin
            stall_cnt_q <= cnt_sat_d;
          end
          if (report_ready) begin
            state_q        <= DEADLOCK;
            report_valid_q <= 1'b0;
            deadlock_q     <= 1'b1;
          end
        end
        DEADLOCK: begin
          if (block) begin
            stall_cnt_q <= cnt_sat_d;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign report_valid = report_valid_q;
  assign report_info  = report_info_q;
  assign report_chan  = report_chan_q;
  assign stall_cnt    = stall_cnt_q;
  assign deadlock     = deadlock_q;

endmodule

// File: tb/tb_deadlock_timeout_ctrl.sv
// Testbench for deadlock_timeout_ctrl (TIMEOUT=8, CNT_W=4, NUM_AXIS=2).
// Each step drives one cycle of inputs, pushes the outputs expected after the
// edge onto a scoreboard queue, then pops and compares them after the edge.
module tb_deadlock_timeout_ctrl;

  localparam int unsigned NUM_AXIS = 2;
  localparam int unsigned INFO_W   = 4;
  localparam int unsigned TIMEOUT  = 8;
  localparam int unsigned CNT_W    = 4;

  typedef struct packed {
    logic              valid;
    logic [INFO_W-1:0] info;
    logic [1:0]        chan;
    logic [CNT_W-1:0]  cnt;
    logic              dl;
  } exp_t;

  logic                clock;
  logic                reset;
  logic                block;
  logic [INFO_W-1:0]   axis_block_info;
  logic                done_in;
  logic                report_valid;
  logic                report_ready;
  logic [INFO_W-1:0]   report_info;
  logic [NUM_AXIS-1:0] report_chan;
  logic [CNT_W-1:0]    stall_cnt;
  logic                deadlock;

  exp_t exp_q[$];
  int   n_total;
  int   n_bad;
  int   n_step;

  deadlock_timeout_ctrl #(
    .NUM_AXIS (NUM_AXIS),
    .INFO_W   (INFO_W),
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (CNT_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .block           (block),
    .axis_block_info (axis_block_info),
    .done_in         (done_in),
    .report_valid    (report_valid),
    .report_ready    (report_ready),
    .report_info     (report_info),
    .report_chan     (report_chan),
    .stall_cnt       (stall_cnt),
    .deadlock        (deadlock)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s step=%0d got=%0h exp=%0h", tag, n_step, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, queue expectation, compare after the edge.
  task automatic step(input logic rst, input logic blk, input logic dn, input logic rdy,
                      input logic [INFO_W-1:0] inf,
                      input logic ev, input logic [INFO_W-1:0] einfo,
                      input logic [1:0] echan, input int ecnt, input logic edl);
    exp_t e;
    exp_t o;
    reset           = rst;
    block           = blk;
    done_in         = dn;
    report_ready    = rdy;
    axis_block_info = inf;
    e.valid = ev;
    e.info  = einfo;
    e.chan  = echan;
    e.cnt   = CNT_W'(ecnt);
    e.dl    = edl;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    n_step++;
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      o = exp_q.pop_front();
      check_eq("report_valid", 32'(report_valid), 32'(o.valid));
      check_eq("report_info",  32'(report_info),  32'(o.info));
      check_eq("report_chan",  32'(report_chan),  32'(o.chan));
      check_eq("stall_cnt",    32'(stall_cnt),    32'(o.cnt));
      check_eq("deadlock",     32'(deadlock),     32'(o.dl));
    end
  endtask

  function automatic int sat(input int k);
    return (k > 15) ? 15 : k;
  endfunction

  initial begin
    clock = 1'b0;
    n_total = 0;
    n_bad = 0;
    n_step = 0;
    reset = 1'b1;
    block = 1'b0;
    done_in = 1'b0;
    report_ready = 1'b0;
    axis_block_info = '0;

    // Reset state
    step(1, 1, 0, 1, 4'hF, 0, 4'h0, 2'b00, 0, 0);
    step(1, 0, 0, 0, 4'h0, 0, 4'h0, 2'b00, 0, 0);
    step(0, 0, 0, 0, 4'h0, 0, 4'h0, 2'b00, 0, 0);

    // Short stall: 7 blocked cycles, drop on the threshold sample -> no report
    for (int k = 1; k <= 7; k++) step(0, 1, 0, 0, 4'h6, 0, 4'h0, 2'b00, k, 0);
    step(0, 0, 0, 0, 4'h6, 0, 4'h0, 2'b00, 0, 0);
    step(0, 0, 0, 0, 4'h0, 0, 4'h0, 2'b00, 0, 0);

    // Detection with ready held high throughout (early ready has no effect)
    for (int k = 1; k <= 7; k++) step(0, 1, 0, 1, 4'h1, 0, 4'h0, 2'b00, k, 0);
    step(0, 1, 0, 1, 4'h6, 1, 4'h6, 2'b11, 8, 0);
    for (int k = 9; k <= 20; k++) step(0, 1, 0, 1, 4'h0, 0, 4'h6, 2'b11, sat(k), 1);
    // Terminal: block low / done_in do not clear deadlock, count holds
    step(0, 0, 1, 0, 4'h0, 0, 4'h6, 2'b11, 15, 1);
    step(0, 0, 0, 0, 4'h0, 0, 4'h6, 2'b11, 15, 1);
    step(1, 0, 0, 0, 4'h0, 0, 4'h0, 2'b00, 0, 0);

    // Backpressure plus saturation: ready low for the whole 40-cycle stall
    for (int k = 1; k <= 7; k++) step(0, 1, 0, 0, 4'h3, 0, 4'h0, 2'b00, k, 0);
    step(0, 1, 0, 0, 4'h6, 1, 4'h6, 2'b11, 8, 0);
    for (int k = 9; k <= 40; k++) step(0, 1, 0, 0, 4'h2, 1, 4'h6, 2'b11, sat(k), 0);
    // In REPORT, block low holds the count and done_in is ignored
    step(0, 0, 1, 0, 4'h2, 1, 4'h6, 2'b11, 15, 0);
    step(0, 0, 0, 0, 4'h2, 1, 4'h6, 2'b11, 15, 0);
    // Reset wins over a concurrent handshake
    step(1, 1, 0, 1, 4'h2, 0, 4'h0, 2'b00, 0, 0);
    step(0, 0, 0, 0, 4'h0, 0, 4'h0, 2'b00, 0, 0);

    // Redetection after reset, one channel stalled, handshake after 2 wait cycles
    for (int k = 1; k <= 7; k++) step(0, 1, 0, 0, 4'h0, 0, 4'h0, 2'b00, k, 0);
    step(0, 1, 0, 0, 4'h8, 1, 4'h8, 2'b10, 8, 0);
    step(0, 0, 0, 0, 4'h0, 1, 4'h8, 2'b10, 8, 0);
    step(0, 1, 0, 0, 4'h0, 1, 4'h8, 2'b10, 9, 0);
    step(0, 0, 0, 1, 4'h0, 0, 4'h8, 2'b10, 9, 1);
    step(0, 1, 0, 1, 4'h0, 0, 4'h8, 2'b10, 10, 1);
    step(1, 0, 0, 0, 4'h0, 0, 4'h0, 2'b00, 0, 0);

    // done_in at stall_cnt=5 returns to IDLE; held high it blocks detection
    for (int k = 1; k <= 5; k++) step(0, 1, 0, 0, 4'h5, 0, 4'h0, 2'b00, k, 0);
    for (int k = 0; k < 21; k++) step(0, 1, 1, 1, 4'h5, 0, 4'h0, 2'b00, 0, 0);
    step(0, 0, 0, 0, 4'h0, 0, 4'h0, 2'b00, 0, 0);

    // Low channel only: decode gives 2'b01
    for (int k = 1; k <= 7; k++) step(0, 1, 0, 0, 4'h0, 0, 4'h0, 2'b00, k, 0);
    step(0, 1, 0, 1, 4'h1, 1, 4'h1, 2'b01, 8, 0);
    step(0, 0, 0, 1, 4'h0, 0, 4'h1, 2'b01, 8, 1);

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
